// File: rtl/bus_fifo_pkg.sv
// rtl/bus_fifo_pkg.sv - shared width helpers and constants for the bus FIFO arbiter
package bus_fifo_pkg;

  localparam int STATS_W = 16;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so a full FIFO (count == depth) is distinguishable from empty.
  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

  function automatic int src_w(input int drvrs);
    return (drvrs > 1) ? $clog2(drvrs) : 1;
  endfunction

endpackage

// File: rtl/bus_fifo_chan.sv
// rtl/bus_fifo_chan.sv - single-channel circular FIFO with drop reporting
module bus_fifo_chan
  import bus_fifo_pkg::*;
#(
  parameter int pckg_sz = 40,
  parameter int depth   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [pckg_sz-1:0] din,
  output logic [pckg_sz-1:0] dout,
  output logic               full,
  output logic               pndng,
  output logic               overflow
);

  localparam int PW = ptr_w(depth);
  localparam int CW = cnt_w(depth);

  logic [pckg_sz-1:0] mem [depth];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               wr_ok;

  assign full  = (count == CW'(depth));
  assign pndng = (count != '0);
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign wr_ok = push && (!full || pop);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && !wr_ok;
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr_ok) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bus_fifo_arbiter.sv
// rtl/bus_fifo_arbiter.sv - N-channel FIFO front end with round-robin drain to one output register
// Optional per-channel drop/grant counters enabled by defining BUS_FIFO_STATS_EN.
module bus_fifo_arbiter
  import bus_fifo_pkg::*;
#(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 40,
  parameter int depth   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           push,
  input  logic [drvrs*pckg_sz-1:0]   D_push,
  output logic [drvrs-1:0]           full,
  output logic [drvrs-1:0]           pndng,
  output logic [drvrs-1:0]           overflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [pckg_sz-1:0]         out_data,
`ifdef BUS_FIFO_STATS_EN
  output logic [$clog2(drvrs)-1:0]   out_src,
  output logic [drvrs*STATS_W-1:0]   drop_cnt,
  output logic [drvrs*STATS_W-1:0]   grant_cnt
`else
  output logic [$clog2(drvrs)-1:0]   out_src
`endif
);

  localparam int SW = src_w(drvrs);

  typedef struct packed {
    logic [SW-1:0]      src;
    logic [pckg_sz-1:0] data;
  } beat_t;

  logic [pckg_sz-1:0] chan_dout [drvrs];
  logic [drvrs-1:0]   pop;
  logic [SW-1:0]      last_grant;
  logic [SW-1:0]      gnt_idx;
  logic               gnt_found;
  logic               load;
  beat_t              out_beat;

  for (genvar i = 0; i < drvrs; i++) begin : g_chan
    bus_fifo_chan #(
      .pckg_sz(pckg_sz),
      .depth  (depth)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .push    (push[i]),
      .pop     (pop[i]),
      .din     (D_push[i*pckg_sz +: pckg_sz]),
      .dout    (chan_dout[i]),
      .full    (full[i]),
      .pndng   (pndng[i]),
      .overflow(overflow[i])
    );
  end

  // Output register is free when empty or when its current beat is taken this cycle.
  assign load = !out_valid || out_ready;

  // Scan starts just after the last winner so every pending channel waits at most drvrs-1 grants.
  always_comb begin
    int            c;
    logic [SW-1:0] ci;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    c         = 0;
    ci        = '0;
    for (int k = 1; k <= drvrs; k++) begin
      c = int'(last_grant) + k;
      if (c >= drvrs) c = c - drvrs;
      ci = SW'(c);
      if (!gnt_found && pndng[ci]) begin
        gnt_found = 1'b1;
        gnt_idx   = ci;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load && gnt_found) pop[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_beat   <= '0;
      last_grant <= SW'(drvrs - 1);
    end else if (load) begin
      if (gnt_found) begin
        out_valid     <= 1'b1;
        out_beat.src  <= gnt_idx;
        out_beat.data <= chan_dout[gnt_idx];
        last_grant    <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_data = out_beat.data;
  assign out_src  = out_beat.src;

`ifdef BUS_FIFO_STATS_EN
  // Drops are counted from the registered overflow pulse, one cycle after the drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt  <= '0;
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < drvrs; i++) begin
        if (overflow[i] && (drop_cnt[i*STATS_W +: STATS_W] != {STATS_W{1'b1}}))
          drop_cnt[i*STATS_W +: STATS_W] <= drop_cnt[i*STATS_W +: STATS_W] + STATS_W'(1);
        if (out_valid && out_ready && (out_beat.src == SW'(i)))
          grant_cnt[i*STATS_W +: STATS_W] <= grant_cnt[i*STATS_W +: STATS_W] + STATS_W'(1);
      end
    end
  end
`endif

endmodule
